hs32_ualign_ram: RTL and testbench

HS32_UALIGN_RAM -- requirements
Module: hs32_ualign_ram

---
 rtl/hs32_ram_pkg.sv | 28 ++
 rtl/hs32_ram_lane.sv | 43 ++++
 rtl/hs32_ualign_ram.sv | 160 ++++++++++++++++
 tb/tb_hs32_ualign_ram.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/hs32_ram_pkg.sv
// Shared encodings for the unaligned byte-lane RAM: access sizes, FSM states
// and the size-to-byte-count decode.
package hs32_ram_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  // Reserved size decodes to zero bytes; callers flag it as an error.
  function automatic logic [3:0] size_nbytes(input logic [1:0] size, input int lanes);
    logic [3:0] nb;
    case (size)
      SZ_BYTE: nb = 4'd1;
      SZ_HALF: nb = 4'd2;
      SZ_WORD: nb = 4'(lanes);
      default: nb = 4'd0;
    endcase
    return nb;
  endfunction

endpackage

// File: rtl/hs32_ram_lane.sv
// One byte lane: synchronous single-port RAM with write enable and a
// registered read port that only updates when enabled.
module hs32_ram_lane #(
  parameter int AW = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata
);

  logic [7:0] mem [2**AW];
  logic [7:0] rdata_q;
  logic [7:0] rdata_d;

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (en && we) begin
      mem[addr] <= wdata;
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (en) begin
      rdata_d = mem[addr];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/hs32_ualign_ram.sv
// Byte-addressed RAM with unaligned byte/half/word access split across LANES
// byte-wide lanes; three-state request/response with a one-cycle ready pulse.
module hs32_ualign_ram
  import hs32_ram_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int LANES      = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [1:0]            size,
  input  logic                  rw,
  input  logic                  valid,
  input  logic [8*LANES-1:0]    dwrite,
  output logic [8*LANES-1:0]    dread,
  output logic                  ready,
  output logic                  err
);

  localparam int DW  = 8 * LANES;
  localparam int LB  = $clog2(LANES);
  localparam int WAW = ADDR_WIDTH - LB;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [1:0]            size_q, size_d;
  logic                  rw_q, rw_d;
  logic [DW-1:0]         wdata_q, wdata_d;
  logic                  ready_q, ready_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  rsp_rd_q, rsp_rd_d;
  logic [LB-1:0]         rsp_off_q, rsp_off_d;
  logic [3:0]            rsp_nb_q, rsp_nb_d;

  logic [3:0]            req_nb;
  logic [LB-1:0]         req_off;
  logic [WAW-1:0]        req_wa;
  logic [ADDR_WIDTH:0]   req_end;
  logic                  req_err;
  logic                  in_access;

  logic [LANES-1:0]      lane_act;
  logic [LANES-1:0]      lane_we;
  logic [LB-1:0]         lane_rel  [LANES];
  logic [WAW-1:0]        lane_addr [LANES];
  logic [7:0]            lane_wd   [LANES];
  logic [7:0]            lane_rd   [LANES];
  logic [DW-1:0]         dread_c;

  // Decode of the latched request; the end address carries one extra bit so
  // running past the top of memory shows up as a carry instead of wrapping.
  always_comb begin
    req_nb    = size_nbytes(size_q, LANES);
    req_off   = addr_q[LB-1:0];
    req_wa    = addr_q[ADDR_WIDTH-1:LB];
    req_end   = {1'b0, addr_q} + (ADDR_WIDTH+1)'(req_nb) - (ADDR_WIDTH+1)'(1);
    req_err   = (size_q == SZ_RSVD) || req_end[ADDR_WIDTH];
    in_access = (state_q == ST_ACCESS);
  end

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      lane_rel[i]  = LB'(LB'(i) - req_off);
      lane_act[i]  = (4'(lane_rel[i]) < req_nb);
      lane_addr[i] = (LB'(i) < req_off) ? req_wa + WAW'(1) : req_wa;
      lane_wd[i]   = wdata_q[8*lane_rel[i] +: 8];
      lane_we[i]   = in_access && rw_q && !req_err && lane_act[i];
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    hs32_ram_lane #(
      .AW (WAW)
    ) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (in_access),
      .we    (lane_we[g]),
      .addr  (lane_addr[g]),
      .wdata (lane_wd[g]),
      .rdata (lane_rd[g])
    );
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    size_d    = size_q;
    rw_d      = rw_q;
    wdata_d   = wdata_q;
    rsp_err_d = rsp_err_q;
    rsp_rd_d  = rsp_rd_q;
    rsp_off_d = rsp_off_q;
    rsp_nb_d  = rsp_nb_q;
    ready_d   = in_access;
    case (state_q)
      ST_IDLE: begin
        if (valid) begin
          state_d = ST_ACCESS;
          addr_d  = addr;
          size_d  = size;
          rw_d    = rw;
          wdata_d = dwrite;
        end
      end
      ST_ACCESS: begin
        // Response shaping is captured alongside the lane read so dread
        // stays put until the next response.
        state_d   = ST_RESP;
        rsp_err_d = req_err;
        rsp_rd_d  = !rw_q;
        rsp_off_d = req_off;
        rsp_nb_d  = req_nb;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      size_q    <= SZ_BYTE;
      rw_q      <= 1'b0;
      wdata_q   <= '0;
      ready_q   <= 1'b0;
      rsp_err_q <= 1'b0;
      rsp_rd_q  <= 1'b0;
      rsp_off_q <= '0;
      rsp_nb_q  <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      size_q    <= size_d;
      rw_q      <= rw_d;
      wdata_q   <= wdata_d;
      ready_q   <= ready_d;
      rsp_err_q <= rsp_err_d;
      rsp_rd_q  <= rsp_rd_d;
      rsp_off_q <= rsp_off_d;
      rsp_nb_q  <= rsp_nb_d;
    end
  end

  always_comb begin
    dread_c = '0;
    for (int k = 0; k < LANES; k++) begin
      if (rsp_rd_q && !rsp_err_q && (4'(k) < rsp_nb_q)) begin
        dread_c[8*k +: 8] = lane_rd[LB'(LB'(k) + rsp_off_q)];
      end
    end
  end

  assign dread = dread_c;
  assign ready = ready_q;
  assign err   = rsp_err_q;

endmodule

// File: tb/tb_hs32_ualign_ram.sv
// Bench for hs32_ualign_ram (LANES=4, ADDR_WIDTH=8): directed vector table,
// reset-abort sequence and a randomized phase against a byte-array model.
module tb_hs32_ualign_ram;
  import hs32_ram_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [7:0]  addr;
  logic [1:0]  size;
  logic        rw;
  logic        valid;
  logic [31:0] dwrite;
  logic [31:0] dread;
  logic        ready;
  logic        err;

  int total;
  int bad;

  logic [31:0] exp_q[$];
  logic        err_q[$];
  logic        chk_q[$];
  logic [7:0]  ref_mem [256];

  typedef struct {
    logic [7:0]  a;
    logic [1:0]  sz;
    logic        w;
    logic [31:0] d;
    logic [31:0] exp_d;
    logic        exp_e;
  } vec_t;

  vec_t tbl [19];

  hs32_ualign_ram #(
    .ADDR_WIDTH (8),
    .LANES      (4)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .addr   (addr),
    .size   (size),
    .rw     (rw),
    .valid  (valid),
    .dwrite (dwrite),
    .dread  (dread),
    .ready  (ready),
    .err    (err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Reference model: computes the response and commits legal writes.
  task automatic model(input logic [7:0] a, input logic [1:0] sz, input logic w,
                       input logic [31:0] d, output logic [31:0] exp_d, output logic exp_e);
    int nb;
    nb = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : (sz == 2'b10) ? 4 : 0;
    exp_e = (sz == 2'b11) || (int'(a) + nb - 1 > 255);
    exp_d = '0;
    if (!exp_e) begin
      for (int k = 0; k < nb; k++) begin
        if (w) ref_mem[int'(a) + k] = d[8*k +: 8];
        else   exp_d[8*k +: 8] = ref_mem[int'(a) + k];
      end
    end
  endtask

  // Driver: request held one cycle, then junk with valid still high through
  // ACCESS to show it is ignored; response popped from the scoreboard.
  task automatic do_req(input logic [7:0] a, input logic [1:0] sz, input logic w,
                        input logic [31:0] d, input logic [31:0] exp_d, input logic exp_e);
    logic [31:0] e_d;
    logic        e_e;
    logic        e_c;
    exp_q.push_back(exp_d);
    err_q.push_back(exp_e);
    chk_q.push_back(!w || exp_e);
    @(negedge clk);
    addr = a; size = sz; rw = w; dwrite = d; valid = 1'b1;
    @(negedge clk);
    addr = 8'($urandom); size = 2'($urandom); rw = 1'($urandom); dwrite = $urandom;
    check("ready_low_access", {31'd0, ready}, 32'd0);
    @(negedge clk);
    valid = 1'b0;
    e_d = exp_q.pop_front();
    e_e = err_q.pop_front();
    e_c = chk_q.pop_front();
    check("ready_pulse", {31'd0, ready}, 32'd1);
    check("err", {31'd0, err}, {31'd0, e_e});
    if (e_c) check("dread", dread, e_d);
    @(negedge clk);
    check("ready_drop", {31'd0, ready}, 32'd0);
  endtask

  initial begin
    logic [31:0] e_d;
    logic        e_e;
    logic [31:0] old_w0;

    total = 0; bad = 0;
    rst_n = 1'b0; valid = 1'b0; addr = '0; size = '0; rw = 1'b0; dwrite = '0;

    tbl[0]  = '{8'h00, SZ_WORD, 1'b1, 32'h03020100, 32'h0, 1'b0};
    tbl[1]  = '{8'h04, SZ_WORD, 1'b1, 32'h07060504, 32'h0, 1'b0};
    tbl[2]  = '{8'h00, SZ_WORD, 1'b0, 32'h0, 32'h03020100, 1'b0};
    tbl[3]  = '{8'h03, SZ_WORD, 1'b0, 32'h0, 32'h06050403, 1'b0};
    tbl[4]  = '{8'h03, SZ_HALF, 1'b1, 32'h0000BEEF, 32'h0, 1'b0};
    tbl[5]  = '{8'h00, SZ_WORD, 1'b0, 32'h0, 32'hEF020100, 1'b0};
    tbl[6]  = '{8'h04, SZ_WORD, 1'b0, 32'h0, 32'h070605BE, 1'b0};
    tbl[7]  = '{8'h05, SZ_BYTE, 1'b0, 32'h0, 32'h00000005, 1'b0};
    tbl[8]  = '{8'h01, SZ_HALF, 1'b0, 32'h0, 32'h00000201, 1'b0};
    tbl[9]  = '{8'hFE, SZ_BYTE, 1'b1, 32'h000000A5, 32'h0, 1'b0};
    tbl[10] = '{8'hFE, SZ_WORD, 1'b1, 32'h11223344, 32'h0, 1'b1};
    tbl[11] = '{8'h10, SZ_RSVD, 1'b0, 32'h0, 32'h0, 1'b1};
    tbl[12] = '{8'hFE, SZ_BYTE, 1'b0, 32'h0, 32'h000000A5, 1'b0};
    tbl[13] = '{8'hFF, SZ_BYTE, 1'b1, 32'h0000005A, 32'h0, 1'b0};
    tbl[14] = '{8'hFF, SZ_HALF, 1'b0, 32'h0, 32'h0, 1'b1};
    tbl[15] = '{8'hFE, SZ_HALF, 1'b0, 32'h0, 32'h00005AA5, 1'b0};
    tbl[16] = '{8'hFD, SZ_WORD, 1'b0, 32'h0, 32'h0, 1'b1};
    tbl[17] = '{8'h07, SZ_HALF, 1'b1, 32'hFFFFCAFE, 32'h0, 1'b0};
    tbl[18] = '{8'h05, SZ_WORD, 1'b0, 32'h0, 32'hCAFE0605, 1'b0};

    repeat (3) @(negedge clk);
    check("rst_ready", {31'd0, ready}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_dread", dread, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 19; i++) begin
      do_req(tbl[i].a, tbl[i].sz, tbl[i].w, tbl[i].d, tbl[i].exp_d, tbl[i].exp_e);
    end

    // dread must hold through idle cycles after the last response
    repeat (3) @(negedge clk);
    check("dread_hold", dread, 32'hCAFE0605);
    check("ready_idle", {31'd0, ready}, 32'd0);

    // Random phase: fill memory with aligned words, then mixed traffic.
    for (int wi = 0; wi < 64; wi++) begin
      logic [31:0] d;
      d = $urandom;
      model(8'(wi * 4), SZ_WORD, 1'b1, d, e_d, e_e);
      do_req(8'(wi * 4), SZ_WORD, 1'b1, d, e_d, e_e);
    end
    for (int n = 0; n < 80; n++) begin
      logic [7:0]  a;
      logic [1:0]  sz;
      logic        w;
      logic [31:0] d;
      a  = 8'($urandom_range(0, 255));
      sz = 2'($urandom_range(0, 3));
      w  = 1'($urandom_range(0, 1));
      d  = $urandom;
      model(a, sz, w, d, e_d, e_e);
      do_req(a, sz, w, d, e_d, e_e);
    end

    // Reset landing during ACCESS of a write: no response, no write.
    old_w0 = {ref_mem[3], ref_mem[2], ref_mem[1], ref_mem[0]};
    do_req(8'h00, SZ_WORD, 1'b0, 32'h0, old_w0, 1'b0);
    @(negedge clk);
    addr = 8'h00; size = SZ_WORD; rw = 1'b1; dwrite = ~old_w0; valid = 1'b1;
    @(posedge clk);
    #2;
    valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("abort_ready", {31'd0, ready}, 32'd0);
    check("abort_err", {31'd0, err}, 32'd0);
    check("abort_dread", dread, 32'd0);
    @(posedge clk);
    #1;
    check("abort_no_pulse", {31'd0, ready}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_abort_ready", {31'd0, ready}, 32'd0);
    do_req(8'h00, SZ_WORD, 1'b0, 32'h0, old_w0, 1'b0);
    do_req(8'h01, SZ_HALF, 1'b1, 32'h00009A3C, 32'h0, 1'b0);
    do_req(8'h00, SZ_WORD, 1'b0, 32'h0, {old_w0[31:24], 24'h9A3C00 | {16'h0, old_w0[7:0]}}, 1'b0);

    if (exp_q.size() != 0) check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time limit so a stuck run still reports.
  initial begin
    #2000000;
    bad++;
    $display("FAIL timeout: got running want finished");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
